async_fifo_cdc: RTL and testbench



---
 rtl/async_fifo_cdc.sv | 182 ++++++++++++++++++
 tb/tb_async_fifo_cdc.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_cdc.sv
// async_fifo_cdc: dual-clock FIFO carrying W_DATA-bit words from wclk to rclk.
// Pointers are W_ADDR+1 bits (binary plus wrap bit). Each pointer has a
// registered Gray copy, which crosses to the other domain through SYNC_STAGES
// flops and is converted back to binary there. Status on both sides is
// computed from registered pointers only. Because the far pointer always lags,
// the status is conservative.
// Optional macro ASYNC_FIFO_CHECKS_EN: simulation-only checks for push while
// full, pop while empty, and synchronized Gray pointers moving more than one
// bit per destination cycle.
`timescale 1ns/100ps
module async_fifo_cdc #(
    parameter int W_DATA      = 16,
    parameter int W_ADDR      = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic              wclk,
    input  logic              wrst_n,
    input  logic [W_DATA-1:0] wdata,
    input  logic              wpush,
    output logic              wfull,
    output logic              wempty,
    output logic [W_ADDR:0]   wlevel,
    input  logic              rclk,
    input  logic              rrst_n,
    output logic [W_DATA-1:0] rdata,
    input  logic              rpop,
    output logic              rfull,
    output logic              rempty,
    output logic [W_ADDR:0]   rlevel
);

    localparam int DEPTH = 1 << W_ADDR;
    localparam logic [W_ADDR:0] DEPTH_L = {1'b1, {W_ADDR{1'b0}}};

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end

    function automatic logic [W_ADDR:0] bin2gray(input logic [W_ADDR:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [W_ADDR:0] gray2bin(input logic [W_ADDR:0] g);
        logic [W_ADDR:0] b;
        b[W_ADDR] = g[W_ADDR];
        for (int i = W_ADDR - 1; i >= 0; i--) begin
            b[i] = b[i + 1] ^ g[i];
        end
        return b;
    endfunction

    logic [W_DATA-1:0] mem_q [DEPTH];

    // ---------------- write domain ----------------
    logic [W_ADDR:0] wptr_bin_q, wptr_bin_d;
    logic [W_ADDR:0] wptr_gray_q, wptr_gray_d;
    logic [W_ADDR:0] rptr_sync_q [SYNC_STAGES];
    logic [W_ADDR:0] rptr_sync_d [SYNC_STAGES];
    logic [W_ADDR:0] rptr_wside;
    logic            push_ok;

    // Next write pointer and the rptr synchronizer shift.
    always_comb begin
        push_ok     = wpush && !wfull;
        wptr_bin_d  = wptr_bin_q + {{W_ADDR{1'b0}}, push_ok};
        wptr_gray_d = bin2gray(wptr_bin_d);
        rptr_sync_d[0] = rptr_gray_q;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            rptr_sync_d[i] = rptr_sync_q[i - 1];
        end
    end

    // Write-domain pointer and synchronizer registers.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wptr_bin_q  <= '0;
            wptr_gray_q <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                rptr_sync_q[i] <= '0;
            end
        end else begin
            wptr_bin_q  <= wptr_bin_d;
            wptr_gray_q <= wptr_gray_d;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                rptr_sync_q[i] <= rptr_sync_d[i];
            end
        end
    end

    // Storage array; written only on wclk and never reset.
    always_ff @(posedge wclk) begin
        if (push_ok) begin
            mem_q[wptr_bin_q[W_ADDR-1:0]] <= wdata;
        end
    end

    assign rptr_wside = gray2bin(rptr_sync_q[SYNC_STAGES-1]);
    assign wlevel     = wptr_bin_q - rptr_wside;
    assign wfull      = (wlevel == DEPTH_L);
    assign wempty     = (wlevel == '0);

    // ---------------- read domain ----------------
    logic [W_ADDR:0] rptr_bin_q, rptr_bin_d;
    logic [W_ADDR:0] rptr_gray_q, rptr_gray_d;
    logic [W_ADDR:0] wptr_sync_q [SYNC_STAGES];
    logic [W_ADDR:0] wptr_sync_d [SYNC_STAGES];
    logic [W_ADDR:0] wptr_rside;
    logic            pop_ok;

    // Next read pointer and the wptr synchronizer shift.
    always_comb begin
        pop_ok      = rpop && !rempty;
        rptr_bin_d  = rptr_bin_q + {{W_ADDR{1'b0}}, pop_ok};
        rptr_gray_d = bin2gray(rptr_bin_d);
        wptr_sync_d[0] = wptr_gray_q;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            wptr_sync_d[i] = wptr_sync_q[i - 1];
        end
    end

    // Read-domain pointer and synchronizer registers.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rptr_bin_q  <= '0;
            rptr_gray_q <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                wptr_sync_q[i] <= '0;
            end
        end else begin
            rptr_bin_q  <= rptr_bin_d;
            rptr_gray_q <= rptr_gray_d;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                wptr_sync_q[i] <= wptr_sync_d[i];
            end
        end
    end

    assign wptr_rside = gray2bin(wptr_sync_q[SYNC_STAGES-1]);
    assign rlevel     = wptr_rside - rptr_bin_q;
    assign rfull      = (rlevel == DEPTH_L);
    assign rempty     = (rlevel == '0);

    // Show-ahead head word; meaningless while rempty.
    assign rdata = mem_q[rptr_bin_q[W_ADDR-1:0]];

`ifdef ASYNC_FIFO_CHECKS_EN
    logic [W_ADDR:0] chk_rsync_prev_q;
    logic [W_ADDR:0] chk_wsync_prev_q;

    // Write-side checks: illegal push and rptr Gray step size.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            chk_rsync_prev_q <= '0;
        end else begin
            chk_rsync_prev_q <= rptr_sync_q[SYNC_STAGES-1];
            if (wpush && wfull) begin
                $error("async_fifo_cdc: push while full");
            end
            if ($countones(chk_rsync_prev_q ^ rptr_sync_q[SYNC_STAGES-1]) > 1) begin
                $error("async_fifo_cdc: synchronized rptr moved more than one Gray bit");
            end
        end
    end

    // Read-side checks: illegal pop and wptr Gray step size.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            chk_wsync_prev_q <= '0;
        end else begin
            chk_wsync_prev_q <= wptr_sync_q[SYNC_STAGES-1];
            if (rpop && rempty) begin
                $error("async_fifo_cdc: pop while empty");
            end
            if ($countones(chk_wsync_prev_q ^ wptr_sync_q[SYNC_STAGES-1]) > 1) begin
                $error("async_fifo_cdc: synchronized wptr moved more than one Gray bit");
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_async_fifo_cdc.sv
// Bench for async_fifo_cdc: a queue model of accepted words, per-cycle
// conservative-status checks on both sides, and directed fill/drain,
// overflow/underflow, random traffic and clock-period sweeps.
`timescale 1ns/100ps
module tb_async_fifo_cdc;

    localparam int W_DATA = 16;
    localparam int W_ADDR = 3;
    localparam int SYNC   = 2;
    localparam int DEPTH  = 8;

    logic              wclk = 1'b0;
    logic              rclk = 1'b0;
    logic              wrst_n = 1'b1;
    logic              rrst_n = 1'b1;
    logic [W_DATA-1:0] wdata = '0;
    logic              wpush = 1'b0;
    logic              rpop = 1'b0;
    logic              wfull, wempty, rfull, rempty;
    logic [W_ADDR:0]   wlevel, rlevel;
    logic [W_DATA-1:0] rdata;

    real wper = 10.0;
    real rper = 13.0;

    int n_tests = 0;
    int n_fail  = 0;
    int pushes  = 0;
    int pops    = 0;
    bit chk_en  = 1'b0;
    logic [W_DATA-1:0] model_q [$];

    async_fifo_cdc #(.W_DATA(W_DATA), .W_ADDR(W_ADDR), .SYNC_STAGES(SYNC)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .wdata(wdata), .wpush(wpush),
        .wfull(wfull), .wempty(wempty), .wlevel(wlevel),
        .rclk(rclk), .rrst_n(rrst_n), .rdata(rdata), .rpop(rpop),
        .rfull(rfull), .rempty(rempty), .rlevel(rlevel)
    );

    initial forever #(wper / 2.0) wclk = ~wclk;
    initial forever #(rper / 2.0) rclk = ~rclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $realtime);
        end
    endtask

    // Model update: a push is accepted when wpush && !wfull at the wclk edge.
    always @(posedge wclk) begin
        if (wrst_n && wpush && !wfull) begin
            model_q.push_back(wdata);
            pushes++;
        end
    end

    // Model update: a pop is accepted when rpop && !rempty; the popped word must be the oldest.
    always @(posedge rclk) begin
        if (rrst_n && rpop && !rempty) begin
            check("model_nonempty_at_pop", 32'(model_q.size() != 0), 1);
            if (model_q.size() != 0) begin
                check("rdata_at_pop", 32'(rdata), 32'(model_q[0]));
                void'(model_q.pop_front());
            end
            pops++;
        end
    end

    // Write-side status: flags agree with level, level never understates occupancy.
    always @(negedge wclk) begin
        if (chk_en) begin
            check("wfull_vs_wlevel", 32'(wfull), 32'(int'(wlevel) == DEPTH));
            check("wempty_vs_wlevel", 32'(wempty), 32'(int'(wlevel) == 0));
            check("wlevel_ge_occupancy", 32'(int'(wlevel) >= (pushes - pops)), 1);
        end
    end

    // Read-side status and show-ahead data against the model.
    always @(negedge rclk) begin
        if (chk_en) begin
            check("rfull_vs_rlevel", 32'(rfull), 32'(int'(rlevel) == DEPTH));
            check("rempty_vs_rlevel", 32'(rempty), 32'(int'(rlevel) == 0));
            check("rlevel_le_occupancy", 32'(int'(rlevel) <= (pushes - pops)), 1);
            if (!rempty) begin
                check("model_has_head", 32'(model_q.size() != 0), 1);
                if (model_q.size() != 0) begin
                    check("rdata_head", 32'(rdata), 32'(model_q[0]));
                end
            end
        end
    end

    task automatic fill_drain(input logic [W_DATA-1:0] base);
        int k;
        k = 0;
        while (!(wempty && rempty) && k < 2000) begin
            @(negedge wclk);
            k++;
        end
        check("idle_before_fill", 32'(wempty && rempty), 1);

        for (int i = 0; i < DEPTH; i++) begin
            @(negedge wclk);
            wpush = 1'b1;
            wdata = base + W_DATA'(i);
        end
        @(negedge wclk);
        wpush = 1'b0;
        check("fill_wfull", 32'(wfull), 1);
        check("fill_wlevel", 32'(wlevel), 8);

        // ninth push while full must be dropped
        wpush = 1'b1;
        wdata = base + W_DATA'(DEPTH);
        @(negedge wclk);
        wpush = 1'b0;
        check("overflow_wlevel", 32'(wlevel), 8);
        check("overflow_wfull", 32'(wfull), 1);

        k = 0;
        while (!rfull && k < SYNC + 1) begin
            @(posedge rclk);
            @(negedge rclk);
            k++;
        end
        check("fill_rfull", 32'(rfull), 1);
        check("fill_rlevel", 32'(rlevel), 8);

        for (int i = 0; i < DEPTH; i++) begin
            @(negedge rclk);
            check("drain_rdata", 32'(rdata), 32'(base + W_DATA'(i)));
            rpop = 1'b1;
        end
        @(negedge rclk);
        rpop = 1'b0;
        check("drain_rempty", 32'(rempty), 1);
        check("drain_rlevel", 32'(rlevel), 0);

        // pop while empty must be ignored
        rpop = 1'b1;
        @(negedge rclk);
        rpop = 1'b0;
        check("underflow_rlevel", 32'(rlevel), 0);
        check("underflow_rempty", 32'(rempty), 1);

        k = 0;
        while (!wempty && k < SYNC + 1) begin
            @(posedge wclk);
            @(negedge wclk);
            k++;
        end
        check("drain_wempty", 32'(wempty), 1);
        check("drain_wlevel", 32'(wlevel), 0);
    endtask

    task automatic random_traffic(input logic [W_DATA-1:0] base, input int n);
        int p0, q0;
        realtime deadline;
        p0 = pushes;
        q0 = pops;
        deadline = $realtime + n * 2000.0;
        fork
            begin
                forever begin
                    @(negedge wclk);
                    if (pushes - p0 >= n || $realtime > deadline) break;
                    wpush = 1'($urandom_range(0, 1));
                    wdata = base + W_DATA'(pushes - p0);
                end
                wpush = 1'b0;
            end
            begin
                forever begin
                    @(negedge rclk);
                    if (pops - q0 >= n || $realtime > deadline) break;
                    rpop = 1'($urandom_range(0, 1));
                end
                rpop = 1'b0;
            end
        join
        check("traffic_pushed", 32'(pushes - p0), 32'(n));
        check("traffic_popped", 32'(pops - q0), 32'(n));
    endtask

    initial begin
        #1;
        wrst_n = 1'b0;
        rrst_n = 1'b0;
        repeat (3) @(posedge wclk);
        repeat (3) @(posedge rclk);
        @(negedge wclk);
        wrst_n = 1'b1;
        @(negedge rclk);
        rrst_n = 1'b1;
        @(negedge wclk);
        @(negedge rclk);
        check("reset_wempty", 32'(wempty), 1);
        check("reset_wfull", 32'(wfull), 0);
        check("reset_wlevel", 32'(wlevel), 0);
        check("reset_rempty", 32'(rempty), 1);
        check("reset_rfull", 32'(rfull), 0);
        check("reset_rlevel", 32'(rlevel), 0);
        chk_en = 1'b1;

        fill_drain(16'h0000);
        random_traffic(16'h0100, 81);

        for (int s = 0; s < 10; s++) begin
            wper = real'($urandom_range(1, 100));
            rper = real'($urandom_range(1, 100));
            repeat (2) @(negedge wclk);
            repeat (2) @(negedge rclk);
            fill_drain(W_DATA'((s + 1) * 16'h1000));
            random_traffic(W_DATA'((s + 1) * 16'h1000 + 16'h0100), 20);
        end

        repeat (4) @(negedge wclk);
        repeat (4) @(negedge rclk);
        check("final_model_empty", 32'(model_q.size()), 0);
        check("final_push_pop_balance", 32'(pushes - pops), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
